// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and data access.
// Data side wins by default; a streak limit forces a fetch grant after MAX_STREAK data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(LATENCY);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t              state_reg, state_next;
  logic                owner_dm_reg, owner_dm_next;
  logic [3:0]          lat_cnt_reg, lat_cnt_next;
  logic [3:0]          streak_reg, streak_next;
  logic                mem_en_reg, mem_en_next;
  logic                mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0]   dm_rdata_reg, dm_rdata_next;
  logic                if_valid_reg, if_valid_next;
  logic                dm_valid_reg, dm_valid_next;
  logic                grant_dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      owner_dm_reg  <= 1'b0;
      lat_cnt_reg   <= '0;
      streak_reg    <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_valid_reg  <= 1'b0;
      dm_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_dm_reg  <= owner_dm_next;
      lat_cnt_reg   <= lat_cnt_next;
      streak_reg    <= streak_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_valid_reg  <= if_valid_next;
      dm_valid_reg  <= dm_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_dm_next  = owner_dm_reg;
    lat_cnt_next   = lat_cnt_reg;
    streak_next    = streak_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_valid_next  = 1'b0;
    dm_valid_next  = 1'b0;
    grant_dm       = dm_req && !(if_req && (streak_reg == STREAK_MAX));

    case (state_reg)
      IDLE: begin
        if (if_req || dm_req) begin
          owner_dm_next = grant_dm;
          mem_en_next   = 1'b1;
          state_next    = ISSUE;
          if (grant_dm) begin
            mem_we_next    = dm_we;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
            // Streak only counts data grants that actually made a fetch wait.
            if (if_req && (streak_reg != STREAK_MAX)) streak_next = streak_reg + 4'd1;
            else if (!if_req)                         streak_next = '0;
          end else begin
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
            streak_next    = '0;
          end
        end
      end
      ISSUE: begin
        lat_cnt_next = LAT_LOAD;
        state_next   = WAIT;
      end
      WAIT: begin
        lat_cnt_next = lat_cnt_reg - 4'd1;
        // Counter reaches 1 in the cycle the memory presents read data.
        if (lat_cnt_reg == 4'd1) begin
          state_next = DONE;
          if (owner_dm_reg) begin
            dm_rdata_next = mem_rdata;
            dm_valid_next = 1'b1;
          end else begin
            if_rdata_next = mem_rdata;
            if_valid_next = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_valid  = if_valid_reg;
  assign dm_valid  = dm_valid_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign stall_if  = if_req & ~if_valid_reg;
  assign stall_dm  = dm_req & ~dm_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: a transaction-level model predicts every memory issue and completion,
// a monitor pops and compares them as the arbiter presents mem_en and valid pulses.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int L     = 2;
  localparam int MS    = 4;
  localparam int NCYC  = 3000;
  localparam int DRAIN = 80;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          stall_if;
  logic          stall_dm;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(L), .MAX_STREAK(MS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          cyc;
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  txn_t        iq[$];
  txn_t        cq[$];
  txn_t        e;
  logic [31:0] tb_mem    [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  int          checks = 0;
  int          errors = 0;
  int          streak = 0;
  int          free_cyc = 0;
  int          resp_cyc = -1;
  logic [31:0] resp_data = '0;
  logic [31:0] last_if_rd = '0;
  int          rst_cnt = 0;
  bit          rst_drive, rst_prev = 1'b0, active, phase1, g_dm;
  bit          exp_if_v, exp_dm_v;
  bit          if_gnt = 1'b0, dm_gnt = 1'b0, if_zombie = 1'b0, dm_zombie = 1'b0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  task automatic chk(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    for (int c = 0; c < NCYC + DRAIN; c++) begin
      @(negedge clk);
      active = (c < NCYC);
      phase1 = (c < 800);

      // ---- monitor: compare what the arbiter presents this cycle ----
      exp_if_v = (cq.size() > 0) && (cq[0].cyc == c) && !cq[0].dm;
      exp_dm_v = (cq.size() > 0) && (cq[0].cyc == c) &&  cq[0].dm;
      chk("stall_if", c, stall_if, if_req & ~exp_if_v);
      chk("stall_dm", c, stall_dm, dm_req & ~exp_dm_v);

      if (rst_prev) begin
        chk("rst_mem_en", c, mem_en, 0);
        chk("rst_mem_we", c, mem_we, 0);
        chk("rst_mem_addr", c, mem_addr, 0);
        chk("rst_mem_wdata", c, mem_wdata, 0);
        chk("rst_if_valid", c, if_valid, 0);
        chk("rst_dm_valid", c, dm_valid, 0);
        chk("rst_if_rdata", c, if_rdata, 0);
        chk("rst_dm_rdata", c, dm_rdata, 0);
      end

      while (iq.size() > 0 && iq[0].cyc < c) begin
        chk("issue_missing", c, c, iq[0].cyc);
        void'(iq.pop_front());
      end
      if (mem_en) begin
        if (iq.size() == 0) chk("unexpected_mem_en", c, mem_en, 0);
        else begin
          e = iq.pop_front();
          chk("issue_cycle", c, c, e.cyc);
          chk("issue_we", c, mem_we, e.we);
          chk("issue_addr", c, mem_addr, e.addr);
          chk("issue_wdata", c, mem_wdata, e.wdata);
        end
      end

      while (cq.size() > 0 && cq[0].cyc < c) begin
        chk("valid_missing", c, c, cq[0].cyc);
        void'(cq.pop_front());
      end
      if (if_valid || dm_valid) begin
        if (cq.size() == 0) chk("unexpected_valid", c, {if_valid, dm_valid}, 0);
        else begin
          e = cq.pop_front();
          chk("valid_cycle", c, c, e.cyc);
          chk("valid_owner", c, {if_valid, dm_valid}, e.dm ? 2'b01 : 2'b10);
          if (!e.dm) begin
            chk("if_rdata", c, if_rdata, e.rdata);
            last_if_rd = e.rdata;
          end else begin
            if (!e.we) chk("dm_rdata", c, dm_rdata, e.rdata);
            chk("if_rdata_hold", c, if_rdata, last_if_rd);
          end
        end
      end

      // ---- memory responder ----
      if (mem_en) begin
        if (mem_we) tb_mem[mem_addr] = mem_wdata;
        else begin
          resp_cyc  = c + L;
          resp_data = tb_mem.exists(mem_addr) ? tb_mem[mem_addr] : init_val(mem_addr);
        end
      end
      mem_rdata = (c == resp_cyc) ? resp_data : $urandom;

      // ---- requesters ----
      rst_drive = 1'b0;
      if (c < 3) rst_drive = 1'b1;
      else if (rst_cnt > 0) begin rst_drive = 1'b1; rst_cnt--; end
      else if (active && $urandom_range(149) == 0) begin
        rst_drive = 1'b1;
        rst_cnt   = int'($urandom_range(1));
      end

      if (exp_if_v) begin if_req = 1'b0; if_gnt = 1'b0; if_zombie = 1'b0; end
      if (exp_dm_v) begin dm_req = 1'b0; dm_gnt = 1'b0; dm_zombie = 1'b0; end

      if (!if_req && !if_zombie) begin
        if (active && (phase1 || $urandom_range(3) == 0)) begin
          if_req  = 1'b1;
          if_addr = 32'h0040_0000 | ($urandom_range(15) << 2);
        end
      end else if (if_req && if_gnt) begin
        if_addr = $urandom;
        if ($urandom_range(19) == 0) begin if_req = 1'b0; if_zombie = 1'b1; end
      end

      if (!dm_req && !dm_zombie) begin
        if (active && (phase1 || $urandom_range(2) == 0)) begin
          dm_req   = 1'b1;
          dm_we    = phase1 ? 1'b0 : 1'($urandom_range(1));
          dm_addr  = 32'h1001_0000 | ($urandom_range(7) << 2);
          dm_wdata = $urandom;
        end
      end else if (dm_req && dm_gnt) begin
        dm_addr  = $urandom;
        dm_wdata = $urandom;
        dm_we    = 1'($urandom_range(1));
        if ($urandom_range(19) == 0) begin dm_req = 1'b0; dm_zombie = 1'b1; end
      end

      // ---- reference model: decide what the edge ending this cycle does ----
      if (rst_drive) begin
        iq.delete();
        cq.delete();
        streak     = 0;
        free_cyc   = c + 1;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        if_zombie  = 1'b0;
        dm_zombie  = 1'b0;
        last_if_rd = '0;
      end else if (c >= free_cyc && (if_req || dm_req)) begin
        g_dm = dm_req && !(if_req && streak == MS);
        if (g_dm) streak = if_req ? ((streak < MS) ? streak + 1 : MS) : 0;
        else      streak = 0;
        e.cyc   = c + 1;
        e.dm    = g_dm;
        e.we    = g_dm && dm_we;
        e.addr  = g_dm ? dm_addr : if_addr;
        e.wdata = g_dm ? dm_wdata : 32'h0;
        e.rdata = model_mem.exists(e.addr) ? model_mem[e.addr] : init_val(e.addr);
        if (e.we) model_mem[e.addr] = e.wdata;
        iq.push_back(e);
        e.cyc = c + L + 2;
        cq.push_back(e);
        free_cyc = c + L + 3;
        if (g_dm) dm_gnt = 1'b1;
        else      if_gnt = 1'b1;
      end

      reset    = rst_drive;
      rst_prev = rst_drive;
    end

    chk("issue_queue_drained", NCYC + DRAIN, iq.size(), 0);
    chk("valid_queue_drained", NCYC + DRAIN, cq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch stage (IF) and the data-memory stage (DM) of the 5-stage MIPS pipeline.
- Sequences each access: grant, issue, wait for latency, return.
- Produces per-requester stall levels that the pipeline ORs with the load-use stall.
- Data side normally wins; a streak limit guarantees fetch progress.

Parameters:
- ADDR_W, 32, memory address width (byte address, passed through unchanged).
- DATA_W, 32, memory data width.
- LATENCY, 2, cycles from mem_en high to mem_rdata valid; legal range 1..15.
- MAX_STREAK, 4, maximum consecutive DM grants while if_req is pending; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_valid.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction; valid when if_valid is high.
- if_valid  out  1  one-cycle completion pulse for a fetch.
- dm_req  in  1  data request; level, held until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; valid when dm_valid is high.
- dm_valid  out  1  one-cycle completion pulse for a data access.
- stall_if  out  1  combinational: if_req & ~if_valid.
- stall_dm  out  1  combinational: dm_req & ~dm_valid.
- mem_en  out  1  registered one-cycle access strobe to memory.
- mem_we  out  1  registered write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data; valid LATENCY cycles after mem_en.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Internal registers: owner (IF/DM), a 4-bit latency counter, a 4-bit streak counter.
- IDLE: on a clock edge with any request sampled high, choose the owner.
  - Owner is DM if dm_req is high and NOT (if_req is high and streak == MAX_STREAK).
  - Otherwise the owner is IF.
  - Latch the owner's addr/we/wdata into the mem_* registers. For IF, mem_we = 0 and mem_wdata = 0.
  - Go to ISSUE.
- ISSUE: mem_en = 1 for exactly this cycle (call it cycle T). Load the counter with LATENCY. Go to WAIT.
- WAIT: decrement the counter each cycle.
  - In cycle T+LATENCY, capture mem_rdata into the owner's rdata register. Capture for writes too; the value is don't-care and must not be relied on.
  - Go to DONE.
- DONE (cycle T+LATENCY+1): the owner's valid = 1 for this single cycle. Go to IDLE. No new grant is made in DONE.
- Latency: request first sampled at edge entering T, so mem_en in T and valid in T+LATENCY+1. Minimum spacing between mem_en pulses is LATENCY+3 cycles.
- if_rdata / dm_rdata hold their last captured value until overwritten. Only the owner's rdata register updates.
- Streak counter:
  - Increments (saturating at MAX_STREAK) on each DM grant made while if_req is high.
  - Clears on any IF grant.
  - Clears on a DM grant made while if_req is low.
- Simultaneous requests with streak < MAX_STREAK: DM wins.
- Simultaneous requests with streak == MAX_STREAK: IF wins and the streak clears.
- Request dropped mid-transaction: the access runs to completion (stores still commit) and valid still pulses. The requester must ignore it.
- Address/data inputs may change after the grant; only the values latched at the grant are used.
- mem_we, mem_addr and mem_wdata hold their values outside ISSUE. Memory must qualify them with mem_en.
- Reset, whether idle or mid-operation:
  - Next cycle: state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0, counters=0.
  - An in-flight access is abandoned: no valid pulse, and data returned later is ignored.
  - Requests held through reset are granted normally after reset deasserts.
- stall_if / stall_dm are purely combinational from req and valid, including during reset.

Test Plan:
- Single fetch, LATENCY=2: if_req=1, if_addr=0x0040_0000, memory returns 0x2008_0005 → mem_en in cycle T with mem_addr=0x0040_0000 and mem_we=0; if_valid in T+3 with if_rdata=0x2008_0005; stall_if high from request until the valid cycle.
- Store: dm_req=1, dm_we=1, dm_addr=0x1001_0004, dm_wdata=0xDEAD_BEEF → one mem_en cycle with mem_we=1 and matching addr/wdata; dm_valid in T+3; if_valid stays 0.
- Contention: if_req and dm_req both held, loads only, MAX_STREAK=4 → grant order DM,DM,DM,DM,IF,DM,…; the IF grant is the 5th; mem_en pulses spaced exactly 5 cycles apart.
- Reset mid-WAIT: reset asserted in cycle T+1 for 1 cycle → no valid pulse; all outputs 0 the cycle after reset; with dm_req still high, a fresh mem_en 2 cycles after reset deasserts.
- Dropped request: dm_req falls in cycle T+1 of a load → mem_en pulse unaffected and dm_valid still pulses in T+3; a waiting if_req is then granted with its mem_en in T+5.
- LATENCY=1 build: single load → valid in T+2; back-to-back loads give mem_en spacing of 4 cycles.
